instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 92 +++++++++
 tb/tb_instr_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: a small loadable program store and a fetch sequencer.
// Words are fetched in order until the HALT_WORD sentinel is reached.
module instr_fetch #(
  parameter int unsigned DEPTH     = 32,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        load_en,
  input  logic [4:0]  load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [4:0]  pc,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [4:0] LAST = 5'(DEPTH - 1);

  state_t      state, state_next;
  logic [31:0] mem [DEPTH];
  logic [31:0] fetch_word;
  logic [31:0] instr_next;
  logic        valid_next;
  logic [4:0]  pc_next;
  logic [4:0]  pc_inc;

  assign fetch_word = mem[pc];
  assign pc_inc     = (pc == LAST) ? '0 : pc + 5'd1;

  // Store has no reset so a program survives rst and can be replayed.
  always_ff @(posedge clk) begin
    if (!rst && load_en && state != RUN)
      mem[load_addr] <= load_data;
  end

  always_comb begin
    state_next = state;
    instr_next = instruction;
    valid_next = instr_valid;
    pc_next    = pc;
    case (state)
      IDLE, HALT: begin
        instr_next = HALT_WORD;
        valid_next = 1'b0;
        if (start) begin
          state_next = RUN;
          pc_next    = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (fetch_word == HALT_WORD) begin
            // pc stays on the halt word so it is visible to the host.
            state_next = HALT;
            instr_next = HALT_WORD;
            valid_next = 1'b0;
          end else begin
            instr_next = fetch_word;
            valid_next = 1'b1;
            pc_next    = pc_inc;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instruction <= HALT_WORD;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instruction <= instr_next;
      instr_valid <= valid_next;
      busy        <= (state_next == RUN);
      halted      <= (state_next == HALT);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed program scenarios followed by random traffic,
// every cycle compared against a behavioural model of the fetch unit.
module tb_instr_fetch;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;
  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst, start, stall, load_en;
  logic [4:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        busy, halted;

  int errors = 0;
  int checks = 0;

  // Behavioural model
  logic [31:0] m_mem [DEPTH];
  bit          m_running = 0;
  bit          m_stopped = 0;
  int unsigned m_pc = 0;
  logic [31:0] m_instr = HW;
  bit          m_valid = 0;

  instr_fetch #(.DEPTH(32), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit st, input bit le,
                            input logic [4:0] la, input logic [31:0] ld);
    logic [31:0] w;
    if (r) begin
      m_running = 0; m_stopped = 0; m_pc = 0; m_instr = HW; m_valid = 0;
      return;
    end
    if (!m_running) begin
      if (le) m_mem[la] = ld;
      m_instr = HW; m_valid = 0;
      if (s) begin
        m_running = 1; m_stopped = 0; m_pc = 0;
      end
    end else if (!st) begin
      w = m_mem[m_pc];
      if (w == HW) begin
        m_running = 0; m_stopped = 1; m_instr = HW; m_valid = 0;
      end else begin
        m_instr = w; m_valid = 1; m_pc = (m_pc + 1) % DEPTH;
      end
    end
  endtask

  // Drive inputs, take one clock edge, then compare all outputs with the model.
  task automatic step(input bit r, input bit s, input bit st, input bit le,
                      input logic [4:0] la, input logic [31:0] ld);
    rst = r; start = s; stall = st; load_en = le; load_addr = la; load_data = ld;
    @(posedge clk);
    model_edge(r, s, st, le, la, ld);
    #1;
    check("instruction", instruction, m_instr);
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("pc", 32'(pc), m_pc);
    check("busy", 32'(busy), 32'(m_running));
    check("halted", 32'(halted), 32'(m_stopped));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 5'd0, 32'd0);
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    step(0, 0, 0, 1, a, d);
  endtask

  initial begin
    rst = 1; start = 0; stall = 0; load_en = 0; load_addr = '0; load_data = '0;
    #1;

    // Reset state
    step(1, 0, 0, 0, 5'd0, 32'd0);
    check("rst_instr", instruction, HW);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Basic program, remaining store filled with non-halt words
    load(5'd0, 32'h0000_FFFF);
    load(5'd1, 32'h0200_EEEE);
    load(5'd2, 32'h0640_0000);
    load(5'd3, HW);
    for (int unsigned i = 4; i < DEPTH; i++) load(5'(i), 32'h1000_0000 + i);

    step(0, 1, 0, 0, 5'd0, 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_pc", 32'(pc), 32'd0);
    idle(); check("p1_w0", instruction, 32'h0000_FFFF); check("p1_v0", 32'(instr_valid), 32'd1);
    idle(); check("p1_w1", instruction, 32'h0200_EEEE);
    idle(); check("p1_w2", instruction, 32'h0640_0000); check("p1_v2", 32'(instr_valid), 32'd1);
    idle();
    check("p1_halt_valid", 32'(instr_valid), 32'd0);
    check("p1_halted", 32'(halted), 32'd1);
    check("p1_halt_pc", 32'(pc), 32'd3);

    // Load during RUN is ignored; load in HALT takes effect on the next run
    step(0, 1, 0, 0, 5'd0, 32'd0);
    step(0, 0, 0, 1, 5'd1, 32'h2400_0001);
    idle(); check("run_load_ignored", instruction, 32'h0200_EEEE);
    idle(); idle();
    check("p2_halted", 32'(halted), 32'd1);
    load(5'd1, 32'h2400_0001);
    step(0, 1, 0, 0, 5'd0, 32'd0);
    idle(); check("p3_w0", instruction, 32'h0000_FFFF);
    idle(); check("p3_w1_new", instruction, 32'h2400_0001);
    idle(); idle();
    load(5'd1, 32'h0200_EEEE);

    // Reset in the second RUN cycle aborts, then the program replays
    step(0, 1, 0, 0, 5'd0, 32'd0);
    idle();
    step(1, 0, 0, 0, 5'd0, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pc", 32'(pc), 32'd0);
    check("abort_valid", 32'(instr_valid), 32'd0);
    step(0, 1, 0, 0, 5'd0, 32'd0);
    idle(); check("replay_w0", instruction, 32'h0000_FFFF);
    idle(); idle(); idle();

    // Reset wins over start
    step(1, 1, 0, 0, 5'd0, 32'd0);
    check("rst_start_busy", 32'(busy), 32'd0);
    idle();
    check("rst_start_busy2", 32'(busy), 32'd0);

    // Stall holds instruction and pc; start with load on the same edge
    load(5'd0, 32'h0040_0001);
    load(5'd1, 32'h2200_0001);
    load(5'd2, 32'h6201_0000);
    step(0, 1, 0, 1, 5'd3, HW);
    idle(); check("st_w0", instruction, 32'h0040_0001);
    idle(); check("st_w1", instruction, 32'h2200_0001); check("st_pc0", 32'(pc), 32'd2);
    step(0, 0, 1, 0, 5'd0, 32'd0); check("st_hold1", instruction, 32'h2200_0001); check("st_pc1", 32'(pc), 32'd2);
    step(0, 0, 1, 0, 5'd0, 32'd0); check("st_hold2", instruction, 32'h2200_0001); check("st_pc2", 32'(pc), 32'd2);
    idle(); check("st_w2", instruction, 32'h6201_0000);
    idle(); check("st_halted", 32'(halted), 32'd1); check("st_halt_pc", 32'(pc), 32'd3);

    // Stall ignored in HALT; PC wraps with no halt
    step(0, 0, 1, 0, 5'd0, 32'd0);
    for (int unsigned i = 0; i < DEPTH; i++) load(5'(i), 32'h6C00_0000);
    step(0, 1, 0, 0, 5'd0, 32'd0);
    for (int unsigned i = 0; i < DEPTH; i++) idle();
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_busy", 32'(busy), 32'd1);
    idle();
    check("wrap_refetch", instruction, 32'h6C00_0000);
    check("wrap_pc1", 32'(pc), 32'd1);
    check("wrap_busy2", 32'(busy), 32'd1);
    step(1, 0, 0, 0, 5'd0, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit r, s, st, le;
      logic [31:0] d;
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 3) == 0);
      le = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 5) == 0) ? HW : $urandom;
      step(r, s, st, le, 5'($urandom_range(0, 31)), d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
